// File: rtl/atm_cell_tx.sv
// atm_cell_tx: ATM cell transmitter. It builds 53-byte cells: 5 header bytes
// (GFC/VPI zero, VCI = CID_BASE + port + 1, PTI, CLP, HEC), then 48 payload
// bytes. User cells stream payload from pay_*. When idle_en is set and no
// request is pending, idle cells are emitted with a fixed header and
// IDLE_PAYLOAD filler.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   cell request handshake; req_port, req_pti, req_clp
//   idle_en           allow idle cells when no request is pending
//   pay_data/valid    payload byte stream in; pay_ready consumes a byte
//   tx_data/valid     outgoing cell bytes; tx_ready accepts a byte
//   tx_sof / tx_eof   mark cell byte 0 / cell byte 52
//
// state | meaning
// IDLE  | between cells, accepts a request or starts an idle cell
// HDR   | emitting header bytes H0..H4 (count 0..4)
// PAY   | emitting payload bytes (count 5..52)

module atm_cell_tx #(
    parameter logic [15:0] CID_BASE     = 16'h1000,
    parameter logic [7:0]  IDLE_PAYLOAD = 8'h6A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_port,
    input  logic [2:0] req_pti,
    input  logic       req_clp,
    output logic       req_ready,
    input  logic       idle_en,
    input  logic [7:0] pay_data,
    input  logic       pay_valid,
    output logic       pay_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_sof,
    output logic       tx_eof
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_HDR  = 6'd4;
    localparam logic [5:0] LAST_BYTE = 6'd52;

    state_t     state;
    logic [5:0] count;
    logic       idle_cell;
    logic [7:0] hdr1;
    logic [7:0] hdr2;
    logic [7:0] hdr3;
    logic [7:0] hec;

    // CRC-8 (x^8+x^2+x+1, init 0) over H0..H3 fed MSB-first, bit-serial form.
    function automatic logic [7:0] crc8_hdr(input logic [31:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    logic [15:0] vci;
    logic [7:0]  new_h1;
    logic [7:0]  new_h2;
    logic [7:0]  new_h3;

    always_comb begin
        vci    = CID_BASE + {14'd0, req_port} + 16'd1;
        new_h1 = {4'h0, vci[15:12]};
        new_h2 = vci[11:4];
        new_h3 = {vci[3:0], req_pti, req_clp};
    end

    // A byte leaves on a tx handshake; in a user payload it must also be a
    // payload handshake, which is the same condition because pay_ready=tx_ready.
    logic advance;
    assign advance = tx_valid & tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 6'd0;
            idle_cell <= 1'b0;
            hdr1      <= 8'h00;
            hdr2      <= 8'h00;
            hdr3      <= 8'h00;
            hec       <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    count <= 6'd0;
                    if (req_valid) begin
                        hdr1      <= new_h1;
                        hdr2      <= new_h2;
                        hdr3      <= new_h3;
                        hec       <= crc8_hdr({8'h00, new_h1, new_h2, new_h3}) ^ 8'h55;
                        idle_cell <= 1'b0;
                        state     <= HDR;
                    end else if (idle_en) begin
                        hdr1      <= 8'h00;
                        hdr2      <= 8'h00;
                        hdr3      <= 8'h01;
                        hec       <= crc8_hdr(32'h0000_0001) ^ 8'h55;
                        idle_cell <= 1'b1;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (advance) begin
                        count <= count + 6'd1;
                        if (count == LAST_HDR) begin
                            state <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (advance) begin
                        if (count == LAST_BYTE) begin
                            count <= 6'd0;
                            state <= IDLE;
                        end else begin
                            count <= count + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 6'd0;
                end
            endcase
        end
    end

    // Outputs derive only from registered state (plus the payload stream in
    // user PAY), so they hold while the downstream stalls.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        pay_ready = 1'b0;
        case (state)
            HDR: begin
                tx_valid = 1'b1;
                case (count)
                    6'd0:    tx_data = 8'h00;
                    6'd1:    tx_data = hdr1;
                    6'd2:    tx_data = hdr2;
                    6'd3:    tx_data = hdr3;
                    default: tx_data = hec;
                endcase
            end
            PAY: begin
                if (idle_cell) begin
                    tx_valid = 1'b1;
                    tx_data  = IDLE_PAYLOAD;
                end else begin
                    tx_valid  = pay_valid;
                    tx_data   = pay_data;
                    pay_ready = tx_ready;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = (state == IDLE) & ~rst;
    assign tx_sof    = (state == HDR) & (count == 6'd0);
    assign tx_eof    = (state == PAY) & (count == LAST_BYTE) & tx_valid;

endmodule

// File: tb/tb_atm_cell_tx.sv
module tb_atm_cell_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_port;
    logic [2:0] req_pti;
    logic       req_clp;
    logic       req_ready;
    logic       idle_en;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sof;
    logic       tx_eof;

    atm_cell_tx dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_port  (req_port),
        .req_pti   (req_pti),
        .req_clp   (req_clp),
        .req_ready (req_ready),
        .idle_en   (idle_en),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    bit in_idle_cell = 0;

    // expected entry: {data, sof, eof}
    logic [9:0] exp_q[$];

    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    function automatic logic [7:0] hec_model(input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3);
        logic [7:0] c;
        c = crc_byte(8'h00, 8'h00);
        c = crc_byte(c, b1);
        c = crc_byte(c, b2);
        c = crc_byte(c, b3);
        return c ^ 8'h55;
    endfunction

    task automatic push_byte(input int idx, input logic [7:0] d);
        exp_q.push_back({d, idx == 0, idx == 52});
    endtask

    task automatic push_payload(input logic [7:0] base);
        for (int i = 0; i < 48; i++) push_byte(5 + i, base + 8'(i));
    endtask

    task automatic push_user(input logic [1:0] port, input logic [2:0] pti, input logic clp,
                             input logic [7:0] base);
        logic [15:0] vci;
        logic [7:0] b1, b2, b3;
        vci = 16'h1000 + 16'(port) + 16'd1;
        b1 = {4'h0, vci[15:12]};
        b2 = vci[11:4];
        b3 = {vci[3:0], pti, clp};
        push_byte(0, 8'h00);
        push_byte(1, b1);
        push_byte(2, b2);
        push_byte(3, b3);
        push_byte(4, hec_model(b1, b2, b3));
        push_payload(base);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted byte against the scoreboard, checks
    // output stability while stalled, and pay_ready during idle cells.
    bit         stall = 0;
    logic [9:0] held;
    logic [9:0] got;
    logic [9:0] want;

    always @(negedge clk) begin
        if (rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                total++;
                if (!tx_valid || {tx_data, tx_sof, tx_eof} !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h",
                             tx_valid, {tx_data, tx_sof, tx_eof}, held);
                end
            end
            if (tx_valid && tx_ready) begin
                got = {tx_data, tx_sof, tx_eof};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL tx_byte #%0d: got data=%0h sof=%0b eof=%0b expected data=%0h sof=%0b eof=%0b",
                                 acc_cnt, got[9:2], got[1], got[0], want[9:2], want[1], want[0]);
                    end
                end
                acc_cnt++;
            end
            if (in_idle_cell) begin
                total++;
                if (pay_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_pay_ready: got %0b expected 0", pay_ready);
                end
            end
            stall = tx_valid && !tx_ready;
            held  = {tx_data, tx_sof, tx_eof};
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check({tag, "_tx_sof"}, 32'(tx_sof), 0);
        check({tag, "_tx_eof"}, 32'(tx_eof), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_pay_ready"}, 32'(pay_ready), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    // Runs one cell from IDLE; the caller has already pushed the expectation.
    task automatic run_cell(input bit use_req, input bit use_idle, input logic [1:0] port,
                            input logic [2:0] pti, input logic clp, input logic [7:0] base,
                            input bit rnd, input int abort_at);
        int idx, cyc, start;
        bit fire;
        start     = acc_cnt;
        idx       = 0;
        req_valid = use_req;
        idle_en   = use_idle;
        req_port  = port;
        req_pti   = pti;
        req_clp   = clp;
        pay_data  = base;
        pay_valid = 1'b1;
        tx_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        idle_en   = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            fire = pay_valid && pay_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) idx++;
            if (abort_at >= 0 && acc_cnt - start == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (use_req) begin
                if (idx >= 48) begin
                    pay_valid = 1'b0;
                end else if (!(pay_valid && !fire)) begin
                    pay_data  = base + 8'(idx);
                    pay_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end
            tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL cell_timeout: got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
        pay_valid = 1'b0;
        tx_ready  = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_port  = 2'd0;
        req_pti   = 3'd0;
        req_clp   = 1'b0;
        idle_en   = 1'b0;
        pay_data  = 8'h00;
        pay_valid = 1'b0;
        tx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // port 0, PTI 0, CLP 0, payload 00..2F
        push_byte(0, 8'h00); push_byte(1, 8'h01); push_byte(2, 8'h00);
        push_byte(3, 8'h10); push_byte(4, 8'h4E);
        push_payload(8'h00);
        run_cell(1, 0, 2'd0, 3'b000, 1'b0, 8'h00, 0, -1);

        // port 3, PTI 001, CLP 1
        push_byte(0, 8'h00); push_byte(1, 8'h01); push_byte(2, 8'h00);
        push_byte(3, 8'h43); push_byte(4, hec_model(8'h01, 8'h00, 8'h43));
        push_payload(8'h40);
        run_cell(1, 0, 2'd3, 3'b001, 1'b1, 8'h40, 0, -1);

        // idle cell, payload offered but must not be consumed
        push_byte(0, 8'h00); push_byte(1, 8'h00); push_byte(2, 8'h00);
        push_byte(3, 8'h01); push_byte(4, 8'h52);
        for (int i = 0; i < 48; i++) push_byte(5 + i, 8'h6A);
        in_idle_cell = 1;
        run_cell(0, 1, 2'd0, 3'b000, 1'b0, 8'h99, 1, -1);
        in_idle_cell = 0;

        // random stalls on both sides
        push_user(2'd2, 3'b101, 1'b0, 8'h80);
        run_cell(1, 0, 2'd2, 3'b101, 1'b0, 8'h80, 1, -1);

        // request and idle_en together: user cell wins
        push_user(2'd1, 3'b010, 1'b1, 8'hC0);
        run_cell(1, 1, 2'd1, 3'b010, 1'b1, 8'hC0, 0, -1);

        // reset at byte 20, then a full cell from H0
        push_user(2'd0, 3'b000, 1'b0, 8'h10);
        run_cell(1, 0, 2'd0, 3'b000, 1'b0, 8'h10, 0, 20);
        @(posedge clk); #1;
        push_user(2'd3, 3'b111, 1'b1, 8'h20);
        run_cell(1, 0, 2'd3, 3'b111, 1'b1, 8'h20, 1, -1);

        // nothing further may be emitted with no request and idle_en low
        repeat (5) @(posedge clk);
        #1;
        check("quiet_tx_valid", 32'(tx_valid), 0);
        check("quiet_req_ready", 32'(req_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
